// File: rtl/wishbone_master_kuyruklu_if.sv
// Bundles the CPU command port, the response port and the Wishbone B4
// master-side bus of the queued Wishbone master. The master modport is the
// block's view; the slave modport is the view of whatever drives the CPU
// side and answers on the bus.
interface wishbone_master_kuyruklu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = DATA_W / 8
);
  // command port
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic              cmd_we_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic [SEL_W-1:0]  cmd_sel_i;
  // response port
  logic              rsp_valid_o;
  logic              rsp_we_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;
  logic              busy_o;
  // Wishbone bus
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              we_o;
  logic [SEL_W-1:0]  sel_o;
  logic              cyc_o;
  logic              stb_o;
  logic              ack_i;
  logic              err_i;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_wdata_i, cmd_sel_i,
    input  dat_i, ack_i, err_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
    output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_wdata_i, cmd_sel_i,
    output dat_i, ack_i, err_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
    input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o
  );
endinterface

// File: rtl/wishbone_master_kuyruklu.sv
// Queued CPU-to-Wishbone master. Commands land in a small FIFO and are issued
// one at a time as classic B4 single cycles. Each finished transfer (ack, err
// or timeout) produces a one-cycle response pulse with data and status.
module wishbone_master_kuyruklu #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = DATA_W / 8,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  wishbone_master_kuyruklu_if.master bus
);

  localparam int IDX_W = $clog2(CMD_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  // The counter only has to reach TIMEOUT_CYC-1.
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
  } cmd_t;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  // FIFO
  cmd_t             r_mem [CMD_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic             w_empty, w_full, w_push, w_pop;
  cmd_t             w_head;

  // FSM and bus registers
  state_t            r_state, w_state_nxt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic              r_we;
  logic [SEL_W-1:0]  r_sel;
  logic              r_cyc;

  // response registers
  logic              r_rsp_valid, r_rsp_we, r_rsp_err, r_rsp_to;
  logic [DATA_W-1:0] r_rsp_rdata;

  // next-cycle decisions
  logic              w_load, w_term, w_rsp_err, w_rsp_to, w_to_hit;
  logic [DATA_W-1:0] w_rsp_rdata;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                   (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
  // Ready comes from registered pointers only, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign w_push  = bus.cmd_valid_i && !w_full;
  assign w_head  = r_mem[r_rptr[IDX_W-1:0]];
  assign w_to_hit = (TIMEOUT_CYC != 0) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[IDX_W-1:0]] <= '{addr:  bus.cmd_addr_i,
                                              we:    bus.cmd_we_i,
                                              wdata: bus.cmd_wdata_i,
                                              sel:   bus.cmd_sel_i};
  end

  // FIFO pointers, flushed by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: start a cycle from the FIFO head, or terminate the
  // current one (err beats ack, ack beats timeout)
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_term      = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_to    = 1'b0;
    w_rsp_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        if (bus.err_i) begin
          w_term    = 1'b1;
          w_rsp_err = 1'b1;
        end else if (bus.ack_i) begin
          w_term      = 1'b1;
          w_rsp_rdata = r_we ? '0 : bus.dat_i;
        end else if (w_to_hit) begin
          w_term    = 1'b1;
          w_rsp_err = 1'b1;
          w_rsp_to  = 1'b1;
        end
        if (w_term) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs: loaded from the head entry, held through BUS, cleared on
  // termination; reads drive zero write data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_adr    <= '0;
      r_dat    <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_cyc    <= 1'b0;
      r_to_cnt <= '0;
    end else if (w_load) begin
      r_adr    <= w_head.addr;
      r_dat    <= w_head.we ? w_head.wdata : '0;
      r_we     <= w_head.we;
      r_sel    <= w_head.sel;
      r_cyc    <= 1'b1;
      r_to_cnt <= '0;
    end else if (w_term) begin
      r_adr    <= '0;
      r_dat    <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_cyc    <= 1'b0;
      r_to_cnt <= '0;
    end else if (r_state == S_BUS) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // One-cycle response pulse; all fields are zero outside the pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_term;
      r_rsp_we    <= w_term && r_we;
      r_rsp_err   <= w_rsp_err;
      r_rsp_to    <= w_rsp_to;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  assign bus.cmd_ready_o   = !w_full;
  assign bus.adr_o         = r_adr;
  assign bus.dat_o         = r_dat;
  assign bus.we_o          = r_we;
  assign bus.sel_o         = r_sel;
  assign bus.cyc_o         = r_cyc;
  assign bus.stb_o         = r_cyc;
  assign bus.rsp_valid_o   = r_rsp_valid;
  assign bus.rsp_we_o      = r_rsp_we;
  assign bus.rsp_err_o     = r_rsp_err;
  assign bus.rsp_timeout_o = r_rsp_to;
  assign bus.rsp_rdata_o   = r_rsp_rdata;
  assign bus.busy_o        = !w_empty || r_cyc || r_rsp_valid;

endmodule

// File: tb/tb_wishbone_master_kuyruklu.sv
// Bench for the queued Wishbone master: directed vector table, hand-written
// multi-cycle sequences and a randomized run, all checked every cycle against
// a queue-based transaction model.
module tb_wishbone_master_kuyruklu;
  localparam int AW = 32, DW = 32, SW = 4, DEPTH = 4, TO = 8;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wishbone_master_kuyruklu_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

  wishbone_master_kuyruklu #(
    .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] sel;
  } cmd_t;
  typedef struct { int delay; int kind; logic [31:0] rdata; } plan_t;
  typedef struct {
    logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] sel;
    int delay; int kind; logic [31:0] rdata;
    logic e_err; logic e_to; logic [31:0] e_rdata; int e_cyc;
  } vec_t;

  int n_cmp = 0, n_bad = 0;

  // stimulus sources
  cmd_t  q_src[$];
  plan_t q_plan[$];
  bit    s_rst = 1'b1, src_rand = 1'b0, junk_en = 1'b0;

  // reference model: what the block should show in the current cycle
  cmd_t  q_fifo[$];
  cmd_t  m_cmd;
  plan_t cur_plan;
  bit    m_known = 1'b0, m_cyc = 1'b0;
  int    m_bus_n = 0;
  bit    m_rv = 1'b0, m_rwe = 1'b0, m_rerr = 1'b0, m_rto = 1'b0;
  logic [31:0] m_rdata = '0;

  // DUT-side observations
  bit    prev_cyc = 1'b0, seen_pulse = 1'b0;
  int    cyc_cnt = 0, gap_cnt = 0, min_gap = 1000, n_rsp = 0, n_acc = 0;
  logic [31:0] cap_adr, cap_dat, cap_rdata;
  logic  cap_we, cap_rwe, cap_err, cap_to;
  logic [3:0] cap_sel;
  int    cap_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check current outputs, observe, drive inputs, advance model.
  task automatic cycle();
    logic a, e, tmo;
    bit   do_push;
    @(negedge clk);
    if (m_known) begin
      chk("cyc_o", bus.cyc_o, m_cyc);
      chk("stb_o", bus.stb_o, m_cyc);
      chk("adr_o", bus.adr_o, m_cyc ? m_cmd.addr : 32'h0);
      chk("dat_o", bus.dat_o, (m_cyc && m_cmd.we) ? m_cmd.wdata : 32'h0);
      chk("we_o", bus.we_o, m_cyc && m_cmd.we);
      chk("sel_o", bus.sel_o, m_cyc ? m_cmd.sel : 4'h0);
      chk("rsp_valid_o", bus.rsp_valid_o, m_rv);
      chk("rsp_we_o", bus.rsp_we_o, m_rwe);
      chk("rsp_err_o", bus.rsp_err_o, m_rerr);
      chk("rsp_timeout_o", bus.rsp_timeout_o, m_rto);
      chk("rsp_rdata_o", bus.rsp_rdata_o, m_rdata);
      chk("cmd_ready_o", bus.cmd_ready_o, q_fifo.size() < DEPTH);
      chk("busy_o", bus.busy_o, (q_fifo.size() > 0) || m_cyc || m_rv);
    end
    // observe the DUT
    if (bus.cyc_o === 1'b1) begin
      if (!prev_cyc) begin
        cyc_cnt = 1;
        cap_adr = bus.adr_o; cap_dat = bus.dat_o; cap_we = bus.we_o; cap_sel = bus.sel_o;
        if (seen_pulse && gap_cnt < min_gap) min_gap = gap_cnt;
      end else cyc_cnt++;
    end else begin
      if (prev_cyc) seen_pulse = 1'b1;
      gap_cnt = prev_cyc ? 1 : gap_cnt + 1;
    end
    prev_cyc = (bus.cyc_o === 1'b1);
    if (bus.rsp_valid_o === 1'b1) begin
      n_rsp++;
      cap_rwe = bus.rsp_we_o; cap_err = bus.rsp_err_o; cap_to = bus.rsp_timeout_o;
      cap_rdata = bus.rsp_rdata_o; cap_cyc = cyc_cnt;
    end
    // drive inputs for the coming edge
    rst = s_rst;
    bus.cmd_valid_i = !s_rst && (q_src.size() > 0) && (!src_rand || ($urandom_range(1, 0) == 1));
    if (bus.cmd_valid_i) begin
      bus.cmd_addr_i = q_src[0].addr; bus.cmd_we_i = q_src[0].we;
      bus.cmd_wdata_i = q_src[0].wdata; bus.cmd_sel_i = q_src[0].sel;
    end else begin
      bus.cmd_addr_i = $urandom; bus.cmd_we_i = 1'($urandom);
      bus.cmd_wdata_i = $urandom; bus.cmd_sel_i = 4'($urandom);
    end
    a = 1'b0; e = 1'b0; bus.dat_i = $urandom;
    if (m_cyc && cur_plan.kind != K_NONE && m_bus_n == cur_plan.delay) begin
      a = (cur_plan.kind == K_ACK) || (cur_plan.kind == K_BOTH);
      e = (cur_plan.kind == K_ERR) || (cur_plan.kind == K_BOTH);
      bus.dat_i = cur_plan.rdata;
    end else if (!m_cyc && junk_en) begin
      a = 1'($urandom); e = 1'($urandom);
    end
    bus.ack_i = a; bus.err_i = e;
    if (bus.cmd_valid_i && bus.cmd_ready_o === 1'b1 && !s_rst) n_acc++;
    // advance the model across the edge
    if (s_rst) begin
      for (int i = 0; i < q_fifo.size(); i++) if (q_plan.size() > 0) void'(q_plan.pop_front());
      q_fifo.delete();
      m_known = 1'b1; m_cyc = 1'b0; m_bus_n = 0;
      m_rv = 1'b0; m_rwe = 1'b0; m_rerr = 1'b0; m_rto = 1'b0; m_rdata = '0;
    end else begin
      do_push = bus.cmd_valid_i && (q_fifo.size() < DEPTH);
      m_rv = 1'b0; m_rwe = 1'b0; m_rerr = 1'b0; m_rto = 1'b0; m_rdata = '0;
      if (m_cyc) begin
        tmo = (m_bus_n == TO);
        if (a || e || tmo) begin
          m_rv = 1'b1; m_rwe = m_cmd.we;
          m_rerr = e || (!a && tmo);
          m_rto = !e && !a && tmo;
          m_rdata = (a && !e && !m_cmd.we) ? bus.dat_i : 32'h0;
          m_cyc = 1'b0;
        end else m_bus_n++;
      end else if (q_fifo.size() > 0) begin
        m_cmd = q_fifo.pop_front();
        m_cyc = 1'b1; m_bus_n = 1;
        if (q_plan.size() > 0) cur_plan = q_plan.pop_front();
        else cur_plan = '{1, K_ACK, 32'h0};
      end
      if (do_push) q_fifo.push_back(q_src.pop_front());
    end
  endtask

  task automatic add(input cmd_t c, input plan_t p);
    q_src.push_back(c); q_plan.push_back(p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[7];
    cmd_t  c;
    plan_t p;
    int    r0, a0;
    bit    full_seen;

    vecs[0] = '{32'h2000_0010, 1'b0, 32'h0,         4'hF, 3, K_ACK,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 3};
    vecs[1] = '{32'h0000_0004, 1'b1, 32'h1234_5678, 4'h3, 1, K_ACK,  32'hAAAA_5555, 1'b0, 1'b0, 32'h0,         1};
    vecs[2] = '{32'h0000_0100, 1'b0, 32'h0,         4'h1, 2, K_BOTH, 32'h1111_1111, 1'b1, 1'b0, 32'h0,         2};
    vecs[3] = '{32'h0000_0200, 1'b0, 32'h0,         4'hF, 0, K_NONE, 32'h0,         1'b1, 1'b1, 32'h0,         8};
    vecs[4] = '{32'h0000_0300, 1'b1, 32'hCAFE_F00D, 4'hC, 4, K_ERR,  32'h2222_2222, 1'b1, 1'b0, 32'h0,         4};
    vecs[5] = '{32'h0000_0400, 1'b0, 32'h0,         4'h6, 8, K_ACK,  32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 8};
    vecs[6] = '{32'h0000_0500, 1'b0, 32'h0,         4'hF, 8, K_ERR,  32'h3333_3333, 1'b1, 1'b0, 32'h0,         8};

    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_we_i = 1'b0;
    bus.cmd_wdata_i = '0; bus.cmd_sel_i = '0; bus.dat_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0;

    // reset
    s_rst = 1'b1; cycle(); cycle(); s_rst = 1'b0; cycle();
    chk("rst_cyc", bus.cyc_o, 1'b0);
    chk("rst_ready", bus.cmd_ready_o, 1'b1);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 1'b0);

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      c = '{vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].sel};
      p = '{vecs[i].delay, vecs[i].kind, vecs[i].rdata};
      add(c, p);
      r0 = n_rsp;
      for (int k = 0; k < 40 && n_rsp == r0; k++) cycle();
      chk($sformatf("v%0d_done", i), n_rsp - r0, 1);
      chk($sformatf("v%0d_adr", i), cap_adr, vecs[i].addr);
      chk($sformatf("v%0d_dat", i), cap_dat, vecs[i].we ? vecs[i].wdata : 32'h0);
      chk($sformatf("v%0d_we", i), cap_we, vecs[i].we);
      chk($sformatf("v%0d_sel", i), cap_sel, vecs[i].sel);
      chk($sformatf("v%0d_rsp_we", i), cap_rwe, vecs[i].we);
      chk($sformatf("v%0d_err", i), cap_err, vecs[i].e_err);
      chk($sformatf("v%0d_to", i), cap_to, vecs[i].e_to);
      chk($sformatf("v%0d_rdata", i), cap_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_cyc_len", i), cap_cyc, vecs[i].e_cyc);
      cycle(); cycle();
    end

    // six back-to-back commands against a stalled slave
    min_gap = 1000; seen_pulse = 1'b0; a0 = n_acc; r0 = n_rsp; full_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c = '{32'h100 + 32'(i * 4), 1'(i), $urandom, 4'hF};
      p = '{(i == 0) ? 7 : 2, K_ACK, $urandom};
      add(c, p);
    end
    for (int k = 0; k < 300 && (n_rsp - r0) < 6; k++) begin
      cycle();
      if (!full_seen && bus.cmd_ready_o === 1'b0) begin
        full_seen = 1'b1;
        chk("t3_accepted_at_full", n_acc - a0, 5);
        chk("t3_cyc_at_full", bus.cyc_o, 1'b1);
      end
    end
    chk("t3_full_seen", full_seen, 1'b1);
    chk("t3_responses", n_rsp - r0, 6);
    chk("t3_min_gap", min_gap, 1);
    cycle(); cycle();

    // timeout followed by a queued command that starts right after it
    r0 = n_rsp;
    add('{32'h700, 1'b0, 32'h0, 4'hF}, '{0, K_NONE, 32'h0});
    add('{32'h704, 1'b0, 32'h0, 4'hF}, '{1, K_ACK, 32'h5A5A_A5A5});
    for (int k = 0; k < 40 && n_rsp == r0; k++) cycle();
    chk("t5_to_flag", cap_to, 1'b1);
    chk("t5_to_len", cap_cyc, TO);
    for (int k = 0; k < 40 && n_rsp == r0 + 1; k++) cycle();
    chk("t5_next_rdata", cap_rdata, 32'h5A5A_A5A5);
    chk("t5_next_to", cap_to, 1'b0);
    cycle(); cycle();

    // reset in the 2nd BUS cycle with two commands still queued
    for (int i = 0; i < 3; i++) add('{32'h900 + 32'(i), 1'b1, $urandom, 4'hF}, '{0, K_NONE, 32'h0});
    for (int k = 0; k < 40 && !(m_cyc && m_bus_n == 2); k++) cycle();
    chk("t6_reached_bus2", m_cyc && m_bus_n == 2, 1'b1);
    r0 = n_rsp;
    s_rst = 1'b1; cycle(); s_rst = 1'b0; cycle();
    chk("t6_cyc", bus.cyc_o, 1'b0);
    chk("t6_stb", bus.stb_o, 1'b0);
    chk("t6_busy", bus.busy_o, 1'b0);
    chk("t6_ready", bus.cmd_ready_o, 1'b1);
    for (int k = 0; k < 5; k++) cycle();
    chk("t6_no_rsp", n_rsp - r0, 0);

    // randomized traffic
    r0 = n_rsp; src_rand = 1'b1; junk_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      c = '{$urandom, 1'($urandom), $urandom, 4'($urandom)};
      p = '{int'($urandom_range(9, 1)), int'($urandom_range(3, 0)), $urandom};
      add(c, p);
    end
    for (int k = 0; k < 6000 && (n_rsp - r0) < 200; k++) cycle();
    chk("rand_responses", n_rsp - r0, 200);
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wishbone_master_kuyruklu.md
Name: wishbone_master_kuyruklu

Overview:
Parametrised successor of the single-shot CPU-to-Wishbone master. It accepts CPU read/write commands through a valid/ready port and buffers them in a CMD_DEPTH command FIFO. It then executes them one at a time as classic Wishbone B4 single cycles, with per-byte select, err_i support and a bus timeout. Every completed transfer, read or write, returns a one-cycle response carrying data and status. It sits between the core's memory stage and the Wishbone interconnect.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; multiple of 8.
SEL_W, DATA_W/8, byte-select width.
CMD_DEPTH, 4, command FIFO depth; power of two, at least 2.
TIMEOUT_CYC, 255, maximum cycles cyc_o may stay high waiting for ack_i/err_i; 0 disables the timeout.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
cmd_valid_i  input  1  command present.
cmd_ready_o  output  1  FIFO can accept; equals !full.
cmd_addr_i  input  ADDR_W  command address.
cmd_we_i  input  1  1 = write, 0 = read.
cmd_wdata_i  input  DATA_W  write data.
cmd_sel_i  input  SEL_W  byte lanes.
rsp_valid_o  output  1  one-cycle response pulse.
rsp_we_o  output  1  response belongs to a write.
rsp_rdata_o  output  DATA_W  read data; 0 for writes, errors and timeouts.
rsp_err_o  output  1  transfer terminated by err_i or by timeout.
rsp_timeout_o  output  1  transfer terminated by timeout.
busy_o  output  1  FIFO non-empty or bus cycle active.
adr_o  output  ADDR_W  Wishbone address.
dat_o  output  DATA_W  Wishbone write data.
dat_i  input  DATA_W  Wishbone read data.
we_o  output  1  Wishbone write enable.
sel_o  output  SEL_W  Wishbone byte select.
cyc_o  output  1  Wishbone cycle.
stb_o  output  1  Wishbone strobe.
ack_i  input  1  slave acknowledge.
err_i  input  1  slave error.

Behaviour:
- Reset (rst_i high at an edge):
  - All registered outputs become 0 at that edge, and cmd_ready_o is 1 from the following cycle.
  - The FIFO is flushed, the timeout counter is cleared and the FSM goes to IDLE.
  - A bus cycle in flight is abandoned: cyc_o/stb_o go low and no response is produced.
- FIFO:
  - A push happens when cmd_valid_i && cmd_ready_o are both high at a clock edge.
  - The FIFO stores {addr, we, wdata, sel}.
  - cmd_ready_o = !full, evaluated from registered state only. A pop in the same cycle does not admit a push while the FIFO is full.
  - Pointers are log2(CMD_DEPTH)+1 bits and wrap modulo 2*CMD_DEPTH. Full is when the pointers differ only in the MSB; empty is when they are equal.
- FSM states: IDLE, BUS.
  - IDLE with the FIFO non-empty: pop the head entry. At the next edge, register adr_o/dat_o/we_o/sel_o from it, set cyc_o=stb_o=1, clear the timeout counter, go to BUS.
  - For read entries, dat_o is registered as 0.
  - IDLE with the FIFO empty: cyc_o=stb_o=0 and adr_o/dat_o/we_o/sel_o=0.
- In BUS:
  - cyc_o, stb_o, adr_o, dat_o, we_o and sel_o are held stable until termination.
  - The timeout counter increments every BUS cycle.
- Termination, sampled at an edge while in BUS. At that edge cyc_o/stb_o and all bus outputs go to 0, rsp_valid_o is set to 1 for exactly one cycle, rsp_we_o = we_o, and the FSM returns to IDLE.
  - err_i=1 (err has priority over ack_i when both are high): rsp_err_o=1, rsp_rdata_o=0.
  - ack_i=1 and err_i=0: rsp_err_o=0. rsp_rdata_o = dat_i for reads and 0 for writes.
  - No ack_i/err_i, TIMEOUT_CYC != 0 and the counter equals TIMEOUT_CYC-1: rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0. cyc_o is therefore high for exactly TIMEOUT_CYC cycles.
- Latency:
  - A command pushed at the edge ending cycle N into an empty, idle block drives cyc_o high in cycle N+2.
  - If ack_i is sampled at the edge ending cycle M, rsp_valid_o is high in cycle M+1 and cyc_o is low in cycle M+1.
  - The next queued command has cyc_o high in cycle M+2 at the earliest, so there is always at least one idle cycle between bus cycles.
- Default outputs:
  - rsp_* fields are 0 whenever rsp_valid_o=0.
  - ack_i/err_i arriving outside BUS are ignored.
- busy_o = !empty || cyc_o || rsp_valid_o.

Test Plan:
1. Reset, then a read to 0x2000_0010 with sel=4'hF; the slave acks in its 3rd BUS cycle with dat_i=0xDEADBEEF -> cyc_o high for 3 cycles, then one rsp_valid_o pulse with rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_we_o=0.
2. A write to 0x0000_0004 with data 0x1234_5678 and sel=4'b0011, immediate ack -> we_o=1, sel_o=0011 and dat_o=0x12345678 during the cycle; response has rsp_we_o=1 and rsp_rdata_o=0.
3. cmd_valid_i held high for 6 commands with the slave stalled -> cmd_ready_o falls after 4 accepted while 1 is in flight on the bus. All commands execute in order, with exactly one idle cycle between cyc_o pulses.
4. Read answered with err_i=1 and ack_i=1 in the same cycle -> rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
5. TIMEOUT_CYC=8 and the slave never answers -> cyc_o high for exactly 8 cycles, then rsp_valid_o with rsp_err_o=1 and rsp_timeout_o=1, and the next queued command starts.
6. rst_i asserted in the 2nd BUS cycle with 2 commands queued -> cyc_o/stb_o are 0 in the next cycle, no rsp_valid_o, busy_o=0 and cmd_ready_o=1 afterwards.
